instr_fetch_stage: RTL and testbench

Fetch stage and IF/ID pipeline register for the LEGv8 datapath. Holds the PC and fetches 32-bit instructions from instruction memory over a req/ack handshake. It presents each instruction to decode with its PC, raw `Imm26` field and the 3-bit `ExtCtrl` code that the sign-extender consumes directly. Supports downstream stall and branch redirect/flush.

---
 rtl/instr_fetch_stage_if.sv | 43 ++++
 rtl/instr_fetch_stage.sv | 181 ++++++++++++++++++
 tb/tb_instr_fetch_stage.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_stage_if.sv
// ============================================================================
//  Module   : instr_fetch_stage_if
//  Brief    : Instruction-memory handshake, pipeline control and IF/ID outputs
//             of the fetch stage. IFS_ILLEGAL_OP_EN adds IdIllegal.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface instr_fetch_stage_if;
    logic        ImemReq;
    logic [63:0] ImemAddr;
    logic        ImemAck;
    logic [31:0] ImemData;
    logic        Stall;
    logic        BranchTaken;
    logic [63:0] BranchTarget;
    logic        IdValid;
    logic [31:0] IdInstr;
    logic [63:0] IdPC;
    logic [25:0] Imm26;
    logic [2:0]  ExtCtrl;
`ifdef IFS_ILLEGAL_OP_EN
    logic        IdIllegal;
`endif

    modport master (
`ifdef IFS_ILLEGAL_OP_EN
        output IdIllegal,
`endif
        output ImemReq, ImemAddr, IdValid, IdInstr, IdPC, Imm26, ExtCtrl,
        input  ImemAck, ImemData, Stall, BranchTaken, BranchTarget
    );

    modport slave (
`ifdef IFS_ILLEGAL_OP_EN
        input  IdIllegal,
`endif
        input  ImemReq, ImemAddr, IdValid, IdInstr, IdPC, Imm26, ExtCtrl,
        output ImemAck, ImemData, Stall, BranchTaken, BranchTarget
    );
endinterface

`default_nettype wire

// File: rtl/instr_fetch_stage.sv
// ============================================================================
//  Module   : instr_fetch_stage
//  Brief    : LEGv8 fetch stage with IF/ID register, skid slot and redirect.
//             Optional macro IFS_ILLEGAL_OP_EN adds the IdIllegal flag.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_fetch_stage #(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  wire logic         CLK,
    input  wire logic         Reset_L,
    instr_fetch_stage_if.master bus
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_FETCH   = 2'd1,
        S_HOLD    = 2'd2,
        S_DISCARD = 2'd3
    } state_t;

    state_t      r_state, w_state;
    logic [63:0] r_pc, w_pc;
    logic [63:0] r_disc_addr, w_disc_addr;
    logic [31:0] r_skid_instr, w_skid_instr;
    logic [63:0] r_skid_pc, w_skid_pc;
    logic        r_id_valid, w_id_valid;
    logic [31:0] r_id_instr, w_id_instr;
    logic [63:0] r_id_pc, w_id_pc;
    logic [2:0]  r_id_ext, w_id_ext;
    logic        r_id_illegal, w_id_illegal;

    logic        w_slot_free;
    logic        w_load_id;
    logic [31:0] w_load_instr;
    logic [63:0] w_load_pc;
    logic [3:0]  w_dec;
    logic [63:0] w_target;
    logic [1:0]  w_unused_tgt_lo;

    // Returns {illegal, ExtCtrl}; first matching pattern wins.
    function automatic logic [3:0] f_decode(input logic [31:0] instr);
        logic [3:0] res;
        if (instr[31:23] == 9'b110100101)
            res = 4'b0100;
        else if (instr[31:26] == 6'b000101)
            res = 4'b0010;
        else if (instr[31:25] == 7'b1011010)
            res = 4'b0011;
        else if (instr[31:21] == 11'b11111000010 || instr[31:21] == 11'b11111000000)
            res = 4'b0001;
        else if (instr[31:22] == 10'b1001000100 || instr[31:22] == 10'b1101000100)
            res = 4'b0000;
        else
            res = 4'b1000;
        return res;
    endfunction

    assign w_target        = {bus.BranchTarget[63:2], 2'b00};
    assign w_unused_tgt_lo = bus.BranchTarget[1:0];
    assign w_slot_free     = !r_id_valid || !bus.Stall;

    always_comb begin
        w_state      = r_state;
        w_pc         = r_pc;
        w_disc_addr  = r_disc_addr;
        w_skid_instr = r_skid_instr;
        w_skid_pc    = r_skid_pc;
        w_id_valid   = r_id_valid;
        w_id_instr   = r_id_instr;
        w_id_pc      = r_id_pc;
        w_id_ext     = r_id_ext;
        w_id_illegal = r_id_illegal;
        w_load_id    = 1'b0;
        w_load_instr = r_skid_instr;
        w_load_pc    = r_skid_pc;
        w_dec        = 4'b0000;

        if (bus.BranchTaken) begin
            w_pc       = w_target;
            w_id_valid = 1'b0;
            case (r_state)
                S_FETCH: begin
                    if (!bus.ImemAck) begin
                        w_state     = S_DISCARD;
                        w_disc_addr = r_pc;
                    end
                end
                // An ack landing with the redirect completes the aborted request.
                S_DISCARD: w_state = bus.ImemAck ? S_FETCH : S_DISCARD;
                default:   w_state = S_FETCH;
            endcase
        end else begin
            if (!bus.Stall)
                w_id_valid = 1'b0;
            case (r_state)
                S_IDLE: w_state = S_FETCH;
                S_FETCH: begin
                    if (bus.ImemAck) begin
                        w_pc = r_pc + 64'd4;
                        if (w_slot_free) begin
                            w_load_id    = 1'b1;
                            w_load_instr = bus.ImemData;
                            w_load_pc    = r_pc;
                        end else begin
                            w_skid_instr = bus.ImemData;
                            w_skid_pc    = r_pc;
                            w_state      = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (!bus.Stall) begin
                        w_load_id = 1'b1;
                        w_state   = S_FETCH;
                    end
                end
                S_DISCARD: begin
                    if (bus.ImemAck)
                        w_state = S_FETCH;
                end
                default: w_state = S_IDLE;
            endcase
        end

        if (w_load_id) begin
            w_dec        = f_decode(w_load_instr);
            w_id_valid   = 1'b1;
            w_id_instr   = w_load_instr;
            w_id_pc      = w_load_pc;
            w_id_ext     = w_dec[2:0];
            w_id_illegal = w_dec[3];
        end
    end

    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            r_state      <= S_IDLE;
            r_pc         <= RESET_PC;
            r_disc_addr  <= RESET_PC;
            r_skid_instr <= 32'd0;
            r_skid_pc    <= 64'd0;
            r_id_valid   <= 1'b0;
            r_id_instr   <= 32'd0;
            r_id_pc      <= 64'd0;
            r_id_ext     <= 3'b000;
            r_id_illegal <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_pc         <= w_pc;
            r_disc_addr  <= w_disc_addr;
            r_skid_instr <= w_skid_instr;
            r_skid_pc    <= w_skid_pc;
            r_id_valid   <= w_id_valid;
            r_id_instr   <= w_id_instr;
            r_id_pc      <= w_id_pc;
            r_id_ext     <= w_id_ext;
            r_id_illegal <= w_id_illegal;
        end
    end

    // In DISCARD the aborted address stays on the bus until its ack returns.
    assign bus.ImemReq  = (r_state == S_FETCH) || (r_state == S_DISCARD);
    assign bus.ImemAddr = (r_state == S_DISCARD) ? r_disc_addr : r_pc;
    assign bus.IdValid  = r_id_valid;
    assign bus.IdInstr  = r_id_instr;
    assign bus.IdPC     = r_id_pc;
    assign bus.Imm26    = r_id_instr[25:0];
    assign bus.ExtCtrl  = r_id_ext;
`ifdef IFS_ILLEGAL_OP_EN
    assign bus.IdIllegal = r_id_illegal;
`else
    logic w_unused_illegal;
    assign w_unused_illegal = r_id_illegal;
`endif

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_stage.sv
// ============================================================================
//  Module   : tb_instr_fetch_stage
//  Brief    : Directed self-checking bench for instr_fetch_stage.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_fetch_stage;

    logic CLK;
    logic Reset_L;
    int   tests;
    int   fails;

    instr_fetch_stage_if bus();

    instr_fetch_stage #(.RESET_PC(64'h0)) dut (
        .CLK     (CLK),
        .Reset_L (Reset_L),
        .bus     (bus.master)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [31:0] mem(input logic [63:0] a);
        case (a)
            64'h00:  mem = 32'h9100_0421;
            64'h04:  mem = 32'h1400_0010;
            64'h08:  mem = 32'hB400_0040;
            64'h0C:  mem = 32'hF840_8020;
            64'h10:  mem = 32'hD2A0_0020;
            64'h14:  mem = 32'h8B00_0000;
            64'h18:  mem = 32'h8B01_0000;
            64'h1C:  mem = 32'h8B02_0000;
            default: mem = 32'h0000_0000;
        endcase
    endfunction

    task automatic ack_cur();
        bus.ImemAck  = 1'b1;
        bus.ImemData = mem(bus.ImemAddr);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        Reset_L          = 1'b0;
        bus.ImemAck      = 1'b0;
        bus.ImemData     = 32'd0;
        bus.Stall        = 1'b0;
        bus.BranchTaken  = 1'b0;
        bus.BranchTarget = 64'd0;

        tick();
        tick();
        chk("rst_req",    {63'd0, bus.ImemReq}, 64'd0);
        chk("rst_addr",   bus.ImemAddr, 64'd0);
        chk("rst_valid",  {63'd0, bus.IdValid}, 64'd0);
        chk("rst_instr",  {32'd0, bus.IdInstr}, 64'd0);
        chk("rst_pc",     bus.IdPC, 64'd0);
        chk("rst_imm",    {38'd0, bus.Imm26}, 64'd0);
        chk("rst_ext",    {61'd0, bus.ExtCtrl}, 64'd0);

        Reset_L = 1'b1;
        tick();                                   // IDLE -> FETCH
        chk("first_req",  {63'd0, bus.ImemReq}, 64'd1);
        chk("first_addr", bus.ImemAddr, 64'h0);
        ack_cur();

        tick();                                   // ADDI in ID
        chk("addi_valid", {63'd0, bus.IdValid}, 64'd1);
        chk("addi_pc",    bus.IdPC, 64'h0);
        chk("addi_instr", {32'd0, bus.IdInstr}, 64'h9100_0421);
        chk("addi_imm",   {38'd0, bus.Imm26}, 64'h100_0421);
        chk("addi_ext",   {61'd0, bus.ExtCtrl}, 64'd0);
        chk("addr4",      bus.ImemAddr, 64'h4);
        ack_cur();

        tick();
        chk("b_pc",       bus.IdPC, 64'h4);
        chk("b_ext",      {61'd0, bus.ExtCtrl}, 64'b010);
        chk("b_valid",    {63'd0, bus.IdValid}, 64'd1);
        chk("addr8",      bus.ImemAddr, 64'h8);
        ack_cur();

        tick();
        chk("cbz_pc",     bus.IdPC, 64'h8);
        chk("cbz_ext",    {61'd0, bus.ExtCtrl}, 64'b011);
        ack_cur();

        tick();
        chk("ldur_pc",    bus.IdPC, 64'hC);
        chk("ldur_ext",   {61'd0, bus.ExtCtrl}, 64'b001);
        ack_cur();

        tick();
        chk("movz_pc",    bus.IdPC, 64'h10);
        chk("movz_ext",   {61'd0, bus.ExtCtrl}, 64'b100);
        chk("addr14",     bus.ImemAddr, 64'h14);
        bus.Stall = 1'b1;
        ack_cur();

        tick();                                   // ack into skid, HOLD
        bus.ImemAck = 1'b0;
        chk("hold_req",   {63'd0, bus.ImemReq}, 64'd0);
        chk("hold_pc",    bus.IdPC, 64'h10);
        chk("hold_valid", {63'd0, bus.IdValid}, 64'd1);
        chk("hold_ext",   {61'd0, bus.ExtCtrl}, 64'b100);

        tick();
        chk("hold2_req",  {63'd0, bus.ImemReq}, 64'd0);
        chk("hold2_pc",   bus.IdPC, 64'h10);

        tick();
        chk("hold3_instr", {32'd0, bus.IdInstr}, 64'hD2A0_0020);
        bus.Stall = 1'b0;

        tick();                                   // skid -> ID
        chk("skid_pc",    bus.IdPC, 64'h14);
        chk("skid_instr", {32'd0, bus.IdInstr}, 64'h8B00_0000);
        chk("skid_valid", {63'd0, bus.IdValid}, 64'd1);
        chk("resume_req", {63'd0, bus.ImemReq}, 64'd1);
        chk("resume_addr", bus.ImemAddr, 64'h18);
        ack_cur();

        tick();
        chk("pc18",       bus.IdPC, 64'h18);
        ack_cur();

        tick();
        chk("pc1c",       bus.IdPC, 64'h1C);
        chk("addr20",     bus.ImemAddr, 64'h20);
        bus.ImemAck      = 1'b0;
        bus.BranchTaken  = 1'b1;
        bus.BranchTarget = 64'h1003;

        tick();                                   // DISCARD
        bus.BranchTaken = 1'b0;
        chk("disc_valid", {63'd0, bus.IdValid}, 64'd0);
        chk("disc_req",   {63'd0, bus.ImemReq}, 64'd1);
        chk("disc_addr",  bus.ImemAddr, 64'h20);

        tick();
        chk("disc2_addr", bus.ImemAddr, 64'h20);
        bus.ImemAck  = 1'b1;
        bus.ImemData = 32'hDEAD_BEEF;

        tick();                                   // stale data dropped
        chk("drop_valid", {63'd0, bus.IdValid}, 64'd0);
        chk("tgt_addr",   bus.ImemAddr, 64'h1000);
        chk("tgt_req",    {63'd0, bus.ImemReq}, 64'd1);
        ack_cur();
        bus.BranchTaken  = 1'b1;
        bus.BranchTarget = 64'hFFFF_FFFF_FFFF_FFFC;

        tick();                                   // branch with ack
        bus.BranchTaken = 1'b0;
        chk("bra_valid",  {63'd0, bus.IdValid}, 64'd0);
        chk("bra_addr",   bus.ImemAddr, 64'hFFFF_FFFF_FFFF_FFFC);
        ack_cur();

        tick();
        bus.ImemAck = 1'b0;
        chk("wrap_valid", {63'd0, bus.IdValid}, 64'd1);
        chk("wrap_pc",    bus.IdPC, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("wrap_addr",  bus.ImemAddr, 64'h0);
        chk("zero_ext",   {61'd0, bus.ExtCtrl}, 64'd0);
`ifdef IFS_ILLEGAL_OP_EN
        chk("illegal",    {63'd0, bus.IdIllegal}, 64'd1);
`endif

        tick();                                   // no new instr, no stall
        chk("idle_valid", {63'd0, bus.IdValid}, 64'd0);

        #2;
        Reset_L = 1'b0;
        #1;
        chk("arst_req",   {63'd0, bus.ImemReq}, 64'd0);
        chk("arst_addr",  bus.ImemAddr, 64'h0);
        chk("arst_pc",    bus.IdPC, 64'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
